// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the runtime-loadable program memory.
// Opcode values match the microprocessor's instruction decoder.
package prog_mem_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StLoad
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_NOP = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_RST = 4'hE;

  localparam logic [11:0] NOP_WORD_DEFAULT = {OP_NOP, 8'h00};

endpackage

// File: rtl/prog_mem_if.sv
// Fetch and program-load signals between the control unit / loader and prog_mem.
interface prog_mem_if #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_en;
  logic [WIDTH-1:0]      data;
  logic                  data_valid;
  logic                  busy;
  logic                  ld_start;
  logic [WIDTH-1:0]      ld_data;
  logic                  ld_valid;
  logic                  ld_last;
  logic                  ld_ready;
  logic                  ld_done;
  logic                  ld_err;

  modport master (
    output addr, rd_en, ld_start, ld_data, ld_valid, ld_last,
    input  data, data_valid, busy, ld_ready, ld_done, ld_err
  );

  modport slave (
    input  addr, rd_en, ld_start, ld_data, ld_valid, ld_last,
    output data, data_valid, busy, ld_ready, ld_done, ld_err
  );

endinterface

// File: rtl/spram_1r1w.sv
// Synchronous-read, synchronous-write storage array with an enabled, resettable
// read register that holds its value when no read is issued.
module spram_1r1w #(
  parameter int unsigned     WIDTH      = 12,
  parameter int unsigned     ADDR_WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rdata_q;

  // Array itself has no reset; the owner fills it after reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= RST_VAL;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem.sv
// Runtime-loadable program memory: NOP fill after reset, streaming program load,
// one-cycle registered instruction fetch stalled by busy.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int unsigned      WIDTH      = 12,
  parameter int unsigned      ADDR_WIDTH = 4,
  parameter logic [WIDTH-1:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input logic        clk_i,
  input logic        rst_i,
  prog_mem_if.slave  bus_io
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] fill_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  data_valid_q;
  logic                  ld_done_q;
  logic                  ld_err_q;

  logic                  in_init;
  logic                  in_idle;
  logic                  in_load;
  logic                  ld_accept;
  logic                  rd_fire;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;

  always_comb begin
    in_init   = (state_q == StInit);
    in_idle   = (state_q == StIdle);
    in_load   = (state_q == StLoad);
    ld_accept = in_load && bus_io.ld_valid;
    rd_fire   = in_idle && bus_io.rd_en;
    mem_we    = in_init || ld_accept;
    mem_waddr = in_init ? fill_q : ptr_q;
    mem_wdata = in_init ? NOP_WORD : bus_io.ld_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StInit;
      fill_q       <= '0;
      ptr_q        <= '0;
      data_valid_q <= 1'b0;
      ld_done_q    <= 1'b0;
      ld_err_q     <= 1'b0;
    end else begin
      data_valid_q <= rd_fire;
      ld_done_q    <= 1'b0;
      unique case (state_q)
        StInit: begin
          fill_q <= fill_q + 1'b1;
          if (fill_q == LastAddr) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (bus_io.ld_start) begin
            ld_err_q <= 1'b0;
            ptr_q    <= '0;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          if (ld_accept) begin
            ptr_q <= ptr_q + 1'b1;
            if (bus_io.ld_last) begin
              ld_done_q <= 1'b1;
              state_q   <= StIdle;
            end else if (ptr_q == LastAddr) begin
              // Array full without a last marker: stop writing and flag it.
              ld_err_q  <= 1'b1;
              ld_done_q <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  spram_1r1w #(
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RST_VAL   (NOP_WORD)
  ) u_spram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (rd_fire),
    .raddr_i(bus_io.addr),
    .rdata_o(mem_rdata)
  );

  assign bus_io.data       = mem_rdata;
  assign bus_io.data_valid = data_valid_q;
  assign bus_io.busy       = !in_idle;
  assign bus_io.ld_ready   = in_load;
  assign bus_io.ld_done    = ld_done_q;
  assign bus_io.ld_err     = ld_err_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: fill, fetch, load, overflow, stall and reset cases.
module tb_prog_mem;
  import prog_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_mem_if #(.WIDTH(12), .ADDR_WIDTH(4)) bus ();

  prog_mem #(
    .WIDTH     (12),
    .ADDR_WIDTH(4),
    .NOP_WORD  (12'hC00)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  typedef struct {
    logic [3:0]  addr;
    logic        rd_en;
    logic [11:0] exp_data;
    logic        exp_dv;
  } vec_t;

  vec_t vecs [6];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    bus.addr     = '0;
    bus.rd_en    = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_data  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Hold reset two edges, check reset outputs, release and count busy cycles
  // with a fetch held on so any leak through busy shows as data_valid.
  task automatic do_reset();
    int n;
    int dv_bad;
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    chk("rst_data", 32'(bus.data), 32'hC00);
    chk("rst_dv", 32'(bus.data_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_ld_done", 32'(bus.ld_done), 32'd0);
    chk("rst_ld_err", 32'(bus.ld_err), 32'd0);
    rst       = 1'b0;
    bus.rd_en = 1'b1;
    bus.addr  = 4'd9;
    n         = 0;
    dv_bad    = 0;
    while (bus.busy && n < 100) begin
      if (bus.data_valid) dv_bad++;
      n++;
      step();
    end
    chk("busy_cycles", 32'(n), 32'd16);
    chk("dv_while_init", 32'(dv_bad), 32'd0);
    bus.rd_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bus.addr  = v.addr;
    bus.rd_en = v.rd_en;
    step();
    bus.rd_en = 1'b0;
    chk({name, "_data"}, 32'(bus.data), 32'(v.exp_data));
    chk({name, "_dv"}, 32'(bus.data_valid), 32'(v.exp_dv));
  endtask

  task automatic fetch(input logic [3:0] a, input logic [11:0] exp, input string name);
    vec_t v;
    v.addr     = a;
    v.rd_en    = 1'b1;
    v.exp_data = exp;
    v.exp_dv   = 1'b1;
    run_vec(v, name);
  endtask

  task automatic fetch_all_nop(input string name);
    for (int i = 0; i < 16; i++) fetch(4'(i), 12'hC00, $sformatf("%s_%0d", name, i));
  endtask

  task automatic overflow_load(input logic hold_fetch, output int dv_bad, output int data_bad);
    dv_bad   = 0;
    data_bad = 0;
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    bus.rd_en    = hold_fetch;
    bus.addr     = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = 12'hEEE;
        for (int g = 0; g < 2; g++) begin
          step();
          if (bus.data_valid) dv_bad++;
          if (bus.data !== 12'hC00) data_bad++;
        end
      end
      bus.ld_valid = 1'b1;
      bus.ld_last  = 1'b0;
      bus.ld_data  = 12'(12'h100 + i);
      step();
      if (bus.data_valid) dv_bad++;
      if (bus.data !== 12'hC00) data_bad++;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] prog [3];
    int dv_bad;
    int data_bad;

    prog[0] = {OP_LDI, 8'h20};
    prog[1] = {OP_INC, 8'h00};
    prog[2] = {OP_ST, 8'h00};

    vecs[0] = '{addr: 4'd0,  rd_en: 1'b1, exp_data: 12'hD20, exp_dv: 1'b1};
    vecs[1] = '{addr: 4'd1,  rd_en: 1'b1, exp_data: 12'h900, exp_dv: 1'b1};
    vecs[2] = '{addr: 4'd2,  rd_en: 1'b1, exp_data: 12'hB00, exp_dv: 1'b1};
    vecs[3] = '{addr: 4'd3,  rd_en: 1'b1, exp_data: 12'hC00, exp_dv: 1'b1};
    vecs[4] = '{addr: 4'd7,  rd_en: 1'b0, exp_data: 12'hC00, exp_dv: 1'b0};
    vecs[5] = '{addr: 4'd15, rd_en: 1'b1, exp_data: 12'hC00, exp_dv: 1'b1};

    // Power-up fill, then every address reads NOP back to back.
    do_reset();
    fetch_all_nop("fill");

    // Three-word program ending in ld_last.
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    chk("load_ready", 32'(bus.ld_ready), 32'd1);
    chk("load_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = prog[i];
      bus.ld_last  = (i == 2);
      step();
      if (i < 2) begin
        chk($sformatf("load_done_early_%0d", i), 32'(bus.ld_done), 32'd0);
      end else begin
        chk("load_done", 32'(bus.ld_done), 32'd1);
        chk("load_ready_after", 32'(bus.ld_ready), 32'd0);
        chk("load_busy_after", 32'(bus.busy), 32'd0);
      end
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    fetch(4'd2, 12'hB00, "first_idle_fetch");
    chk("load_done_pulse", 32'(bus.ld_done), 32'd0);
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("prog_vec%0d", i));

    // 16 words without ld_last, fetch held, gap before word 5.
    overflow_load(1'b1, dv_bad, data_bad);
    chk("ovf_dv_during_load", 32'(dv_bad), 32'd0);
    chk("ovf_data_held", 32'(data_bad), 32'd0);
    chk("ovf_err", 32'(bus.ld_err), 32'd1);
    chk("ovf_done", 32'(bus.ld_done), 32'd1);
    chk("ovf_busy", 32'(bus.busy), 32'd0);
    // 17th word presented in IDLE must not land anywhere.
    bus.ld_valid = 1'b1;
    bus.ld_data  = 12'hFFF;
    step();
    chk("ovf_first_fetch", 32'(bus.data), 32'h100);
    chk("ovf_first_dv", 32'(bus.data_valid), 32'd1);
    chk("ovf_done_pulse", 32'(bus.ld_done), 32'd0);
    chk("ovf_err_sticky", 32'(bus.ld_err), 32'd1);
    step();
    bus.ld_valid = 1'b0;
    bus.rd_en    = 1'b0;
    chk("ovf_word17_not_written", 32'(bus.data), 32'h100);
    fetch(4'd3, 12'h103, "ovf_addr3");
    fetch(4'd5, 12'h105, "ovf_gap_addr5");
    fetch(4'd6, 12'h106, "ovf_gap_addr6");
    fetch(4'd15, 12'h10F, "ovf_addr15");

    // ld_start and a fetch in the same IDLE cycle.
    bus.ld_start = 1'b1;
    bus.rd_en    = 1'b1;
    bus.addr     = 4'd5;
    step();
    bus.ld_start = 1'b0;
    bus.rd_en    = 1'b0;
    chk("start_fetch_data", 32'(bus.data), 32'h105);
    chk("start_fetch_dv", 32'(bus.data_valid), 32'd1);
    chk("start_ready", 32'(bus.ld_ready), 32'd1);
    chk("start_err_cleared", 32'(bus.ld_err), 32'd0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 12'hAAA;
    step();
    bus.ld_data  = 12'hBBB;
    step();
    bus.ld_valid = 1'b0;

    // Reset mid-load refills the whole array.
    do_reset();
    fetch_all_nop("refill");

    // Reset also clears a sticky overflow flag.
    overflow_load(1'b0, dv_bad, data_bad);
    bus.ld_valid = 1'b0;
    chk("ovf2_err", 32'(bus.ld_err), 32'd1);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
